ddma_mmio_driver: RTL and testbench

- Hardware bus initiator that programs the PE's memory-mapped DDMA configuration window exactly as the rv32e core would.
- Writes the DDMA send registers, raises the send command, polls the status register until the transfer finishes, then clears the command.
- Used as a CPU stand-in for NoC traffic benches and as a small offload engine beside the core; it connects to the core-side address/data/write-byte bus.

---
 rtl/ddma_mmio_driver_pkg.sv | 52 +++++
 rtl/ddma_mmio_driver_if.sv | 31 +++
 rtl/ddma_mmio_driver.sv | 187 ++++++++++++++++++
 tb/tb_ddma_mmio_driver.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddma_mmio_driver_pkg.sv
// Shared types and constants for the DDMA MMIO driver: register map,
// FSM state encoding, command/output payloads and the bus byte swap.
package ddma_mmio_driver_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned WB_W   = 4;

  localparam logic [ADDR_W-1:0] DDMA_DEST_OFS   = ADDR_W'('h04);
  localparam logic [ADDR_W-1:0] DDMA_ADDR_OFS   = ADDR_W'('h08);
  localparam logic [ADDR_W-1:0] DDMA_SIZE_OFS   = ADDR_W'('h0C);
  localparam logic [ADDR_W-1:0] DDMA_CMD_OFS    = ADDR_W'('h10);
  localparam logic [ADDR_W-1:0] DDMA_STATUS_OFS = ADDR_W'('h14);

  localparam logic [WB_W-1:0] WB_ALL  = WB_W'('hF);
  localparam logic [WB_W-1:0] WB_NONE = WB_W'('h0);

  typedef enum logic [3:0] {
    IDLE,
    WR_DEST,
    WR_ADDR,
    WR_SIZE,
    WR_CMD_SET,
    POLL_REQ,
    POLL_CHK,
    WR_CMD_CLR,
    DONE
  } ddma_drv_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] dest;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] size;
  } ddma_cmd_t;

  // Everything the driver presents to the outside, registered as one word
  typedef struct packed {
    logic              ready;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [WB_W-1:0]   wb;
  } ddma_drv_out_t;

  // The core bus carries words big-endian; reverse the byte order
  function automatic logic [DATA_W-1:0] endianess(input logic [DATA_W-1:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/ddma_mmio_driver_if.sv
// Command handshake and core-side address/data/write-byte bus of the
// DDMA MMIO driver.
interface ddma_mmio_driver_if;
  import ddma_mmio_driver_pkg::*;

  logic              cmd_valid_in;
  logic              cmd_ready_out;
  logic [DATA_W-1:0] cmd_dest_in;
  logic [DATA_W-1:0] cmd_addr_in;
  logic [DATA_W-1:0] cmd_size_in;
  logic              busy_out;
  logic              done_out;
  logic              error_out;
  logic [ADDR_W-1:0] addr_out;
  logic [DATA_W-1:0] data_out;
  logic [WB_W-1:0]   wb_out;
  logic [DATA_W-1:0] data_in;

  // Driver side: accepts commands, initiates bus cycles
  modport master (
    input  cmd_valid_in, cmd_dest_in, cmd_addr_in, cmd_size_in, data_in,
    output cmd_ready_out, busy_out, done_out, error_out, addr_out, data_out, wb_out
  );

  // Environment side: issues commands, serves the bus
  modport slave (
    output cmd_valid_in, cmd_dest_in, cmd_addr_in, cmd_size_in, data_in,
    input  cmd_ready_out, busy_out, done_out, error_out, addr_out, data_out, wb_out
  );

endinterface

// File: rtl/ddma_mmio_driver.sv
// Bus initiator that programs the DDMA send registers like the core would,
// starts the send, polls status until it completes (or times out), clears it.
module ddma_mmio_driver
  import ddma_mmio_driver_pkg::*;
#(
  parameter logic [ADDR_W-1:0] DDMA_BASE      = 32'h2000_0000,
  parameter logic [7:0]        SEND_IDLE_CODE = 8'h00,
  parameter int unsigned       TIMEOUT_CYCLES = 65535
) (
  input  logic               clock,
  input  logic               reset,
  ddma_mmio_driver_if.master bus
);

  localparam int unsigned      TMO_W    = 32;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  ddma_drv_state_t   state;
  ddma_cmd_t         cmd;
  ddma_drv_out_t     out_q;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              seen_busy;
  logic              aborted;

  ddma_cmd_t         cmd_in_c;
  logic [DATA_W-1:0] status_c;
  logic [7:0]        send_state_c;
  logic              unused_status_c;
  logic              tmo_hit_c;

  assign cmd_in_c        = '{dest: bus.cmd_dest_in, addr: bus.cmd_addr_in, size: bus.cmd_size_in};
  assign status_c        = endianess(bus.data_in);
  assign send_state_c    = status_c[15:8];
  assign unused_status_c = ^{status_c[31:16], status_c[7:0]};
  assign tmo_hit_c       = (tmo_cnt == TMO_LAST);

  // Output word presented while sitting in state s
  function automatic ddma_drv_out_t outputs_for(input ddma_drv_state_t s,
                                                input ddma_cmd_t       c,
                                                input logic            abort);
    ddma_drv_out_t o;
    o      = '0;
    o.busy = (s != IDLE);
    case (s)
      IDLE:       o.ready = 1'b1;
      WR_DEST:    begin
        o.addr = DDMA_BASE + DDMA_DEST_OFS;
        o.data = endianess(c.dest);
        o.wb   = WB_ALL;
      end
      WR_ADDR:    begin
        o.addr = DDMA_BASE + DDMA_ADDR_OFS;
        o.data = endianess(c.addr);
        o.wb   = WB_ALL;
      end
      WR_SIZE:    begin
        o.addr = DDMA_BASE + DDMA_SIZE_OFS;
        o.data = endianess(c.size);
        o.wb   = WB_ALL;
      end
      WR_CMD_SET: begin
        o.addr = DDMA_BASE + DDMA_CMD_OFS;
        o.data = endianess(DATA_W'(1));
        o.wb   = WB_ALL;
      end
      POLL_REQ:   begin
        o.addr = DDMA_BASE + DDMA_STATUS_OFS;
        o.wb   = WB_NONE;
      end
      WR_CMD_CLR: begin
        o.addr = DDMA_BASE + DDMA_CMD_OFS;
        o.data = endianess(DATA_W'(0));
        o.wb   = WB_ALL;
      end
      DONE:       begin
        o.done  = !abort;
        o.error = abort;
      end
      default:    ;
    endcase
    return o;
  endfunction

  // FSM; outputs are registered alongside the state they belong to
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cmd       <= '0;
      out_q     <= '0;
      tmo_cnt   <= '0;
      seen_busy <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Accept only once ready is visible, so the handshake matches the port
          if (bus.cmd_valid_in && out_q.ready) begin
            cmd     <= cmd_in_c;
            aborted <= 1'b0;
            if (cmd_in_c.size == '0) begin
              state <= DONE;
              out_q <= outputs_for(DONE, cmd_in_c, 1'b0);
            end else begin
              state <= WR_DEST;
              out_q <= outputs_for(WR_DEST, cmd_in_c, 1'b0);
            end
          end else begin
            out_q <= outputs_for(IDLE, cmd, 1'b0);
          end
        end
        WR_DEST: begin
          state <= WR_ADDR;
          out_q <= outputs_for(WR_ADDR, cmd, aborted);
        end
        WR_ADDR: begin
          state <= WR_SIZE;
          out_q <= outputs_for(WR_SIZE, cmd, aborted);
        end
        WR_SIZE: begin
          state <= WR_CMD_SET;
          out_q <= outputs_for(WR_CMD_SET, cmd, aborted);
        end
        WR_CMD_SET: begin
          seen_busy <= 1'b0;
          tmo_cnt   <= '0;
          state     <= POLL_REQ;
          out_q     <= outputs_for(POLL_REQ, cmd, aborted);
        end
        POLL_REQ: begin
          if (tmo_hit_c) begin
            aborted <= 1'b1;
            state   <= WR_CMD_CLR;
            out_q   <= outputs_for(WR_CMD_CLR, cmd, 1'b1);
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
            state   <= POLL_CHK;
            out_q   <= outputs_for(POLL_CHK, cmd, aborted);
          end
        end
        POLL_CHK: begin
          // Completion counts only after the engine has been seen leaving idle
          if (tmo_hit_c) begin
            aborted <= 1'b1;
            state   <= WR_CMD_CLR;
            out_q   <= outputs_for(WR_CMD_CLR, cmd, 1'b1);
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (!seen_busy) begin
              if (send_state_c != SEND_IDLE_CODE) begin
                seen_busy <= 1'b1;
              end
              state <= POLL_REQ;
              out_q <= outputs_for(POLL_REQ, cmd, aborted);
            end else if (send_state_c == SEND_IDLE_CODE) begin
              state <= WR_CMD_CLR;
              out_q <= outputs_for(WR_CMD_CLR, cmd, aborted);
            end else begin
              state <= POLL_REQ;
              out_q <= outputs_for(POLL_REQ, cmd, aborted);
            end
          end
        end
        WR_CMD_CLR: begin
          state <= DONE;
          out_q <= outputs_for(DONE, cmd, aborted);
        end
        DONE: begin
          state <= IDLE;
          out_q <= outputs_for(IDLE, cmd, 1'b0);
        end
        default: begin
          state <= IDLE;
          out_q <= outputs_for(IDLE, cmd, 1'b0);
        end
      endcase
    end
  end

  assign bus.cmd_ready_out = out_q.ready;
  assign bus.busy_out      = out_q.busy;
  assign bus.done_out      = out_q.done;
  assign bus.error_out     = out_q.error;
  assign bus.addr_out      = out_q.addr;
  assign bus.data_out      = out_q.data;
  assign bus.wb_out        = out_q.wb;

endmodule

// File: tb/tb_ddma_mmio_driver.sv
// Directed bench for ddma_mmio_driver with a status-register model on the bus.
`timescale 1ns/1ps
module tb_ddma_mmio_driver;
  import ddma_mmio_driver_pkg::*;

  localparam logic [31:0] BASE   = 32'h2000_0000;
  localparam int unsigned TMO    = 20;
  localparam logic [31:0] A_DEST = 32'h2000_0004;
  localparam logic [31:0] A_ADDR = 32'h2000_0008;
  localparam logic [31:0] A_SIZE = 32'h2000_000C;
  localparam logic [31:0] A_CMD  = 32'h2000_0010;
  localparam logic [31:0] A_STAT = 32'h2000_0014;

  logic clock = 1'b0;
  logic reset = 1'b1;

  ddma_mmio_driver_if bus();

  ddma_mmio_driver #(
    .DDMA_BASE      (BASE),
    .SEND_IDLE_CODE (8'h00),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Status model: 0 = busy for 3 polls after each start, 1 = stuck busy, 2 = always idle
  int          status_mode     = 0;
  int          polls_since_set = 0;
  logic [31:0] rd_pending      = 32'h0;

  always @(negedge clock) begin
    logic [7:0] sb;
    sb          = 8'h00;
    bus.data_in = rd_pending;
    rd_pending  = 32'h0;
    if (bus.wb_out == 4'hF && bus.addr_out == A_CMD && bus.data_out == 32'h0100_0000) begin
      polls_since_set = 0;
    end else if (bus.wb_out == 4'h0 && bus.addr_out == A_STAT) begin
      case (status_mode)
        0:       sb = (polls_since_set < 3) ? 8'h01 : 8'h00;
        1:       sb = 8'h01;
        default: sb = 8'h00;
      endcase
      // Byte at [23:16] lands at [15:8] after the big-endian swap
      rd_pending = {8'h00, sb, 16'h0000};
      polls_since_set++;
    end
  end

  // Results of the last run_cmd
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          acc_q[$];
  int          n_done, n_err, done_cyc, err_cyc, clr_cyc, overlap;
  bit          finished;

  // Cycle 0 is the cycle in which the command handshake is seen
  task automatic run_cmd(input logic [31:0] d, input logic [31:0] a, input logic [31:0] s,
                         input int n_cmds, input int max_cycles);
    wr_addr_q.delete(); wr_data_q.delete(); acc_q.delete();
    n_done = 0; n_err = 0; done_cyc = -1; err_cyc = -1; clr_cyc = -1; overlap = 0;
    finished = 1'b0;
    @(negedge clock);
    bus.cmd_dest_in  = d;
    bus.cmd_addr_in  = a;
    bus.cmd_size_in  = s;
    bus.cmd_valid_in = 1'b1;
    for (int c = 0; c < max_cycles; c++) begin
      bit drop;
      drop = 1'b0;
      if (bus.cmd_ready_out && bus.busy_out) overlap++;
      if (bus.wb_out != 4'h0) begin
        wr_addr_q.push_back(bus.addr_out);
        wr_data_q.push_back(bus.data_out);
        if (bus.addr_out == A_CMD && bus.data_out == 32'h0) clr_cyc = c;
      end
      if (bus.done_out)  begin n_done++; done_cyc = c; end
      if (bus.error_out) begin n_err++;  err_cyc  = c; end
      if (bus.cmd_valid_in && bus.cmd_ready_out) begin
        acc_q.push_back(c);
        drop = (acc_q.size() >= n_cmds);
      end else if (acc_q.size() >= n_cmds && (n_done + n_err) >= n_cmds && bus.cmd_ready_out) begin
        finished = 1'b1;
        break;
      end
      @(posedge clock);
      #1;
      if (drop) bus.cmd_valid_in = 1'b0;
      @(negedge clock);
    end
    bus.cmd_valid_in = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    tests++;
    if ({bus.cmd_ready_out, bus.busy_out, bus.done_out, bus.error_out} !== 4'b0000) begin
      fails++; $display("FAIL reset_ctrl: got %b expected 0000",
                        {bus.cmd_ready_out, bus.busy_out, bus.done_out, bus.error_out});
    end
    tests++;
    if ({bus.addr_out, bus.data_out, bus.wb_out} !== 68'h0) begin
      fails++; $display("FAIL reset_bus: got addr %h data %h wb %h expected 0",
                        bus.addr_out, bus.data_out, bus.wb_out);
    end
    reset = 1'b0;
    @(negedge clock);
    tests++;
    if ({bus.cmd_ready_out, bus.busy_out} !== 2'b10) begin
      fails++; $display("FAIL reset_release_ready: got %b expected 10", {bus.cmd_ready_out, bus.busy_out});
    end
  endtask

  task automatic test_normal_send();
    logic [31:0] exp_a[5];
    logic [31:0] exp_d[5];
    exp_a = '{A_DEST, A_ADDR, A_SIZE, A_CMD, A_CMD};
    exp_d = '{32'h0101_0000, 32'h0010_0040, 32'h1000_0000, 32'h0100_0000, 32'h0000_0000};
    status_mode = 0;
    run_cmd(32'h0000_0101, 32'h4000_1000, 32'd16, 1, 100);
    tests++;
    if (finished !== 1'b1) begin fails++; $display("FAIL normal_finish: got %0d expected 1", finished); end
    tests++;
    if (wr_addr_q.size() != 5) begin
      fails++; $display("FAIL normal_wr_count: got %0d expected 5", wr_addr_q.size());
    end
    for (int i = 0; i < 5; i++) begin
      logic [31:0] ga, gd;
      ga = (i < wr_addr_q.size()) ? wr_addr_q[i] : 32'hDEAD_BEEF;
      gd = (i < wr_data_q.size()) ? wr_data_q[i] : 32'hDEAD_BEEF;
      tests++;
      if ({ga, gd} !== {exp_a[i], exp_d[i]}) begin
        fails++; $display("FAIL normal_write%0d: got (%h,%h) expected (%h,%h)", i, ga, gd, exp_a[i], exp_d[i]);
      end
    end
    tests++;
    if ({n_done, n_err} !== {32'd1, 32'd0}) begin
      fails++; $display("FAIL normal_pulses: got done %0d err %0d expected 1/0", n_done, n_err);
    end
    // accept + 4 writes + 4 polls (2 cycles each) + clear -> done in cycle 14
    tests++;
    if (done_cyc != 14 || clr_cyc != 13) begin
      fails++; $display("FAIL normal_timing: got done %0d clr %0d expected 14/13", done_cyc, clr_cyc);
    end
  endtask

  task automatic test_size_zero();
    status_mode = 0;
    run_cmd(32'h0000_0202, 32'h4000_2000, 32'd0, 1, 20);
    tests++;
    if (finished !== 1'b1) begin fails++; $display("FAIL zero_finish: got %0d expected 1", finished); end
    tests++;
    if (wr_addr_q.size() != 0) begin
      fails++; $display("FAIL zero_no_writes: got %0d writes expected 0", wr_addr_q.size());
    end
    // accept cycle then the DONE cycle
    tests++;
    if (done_cyc != 1) begin fails++; $display("FAIL zero_done_cycle: got %0d expected 1", done_cyc); end
    tests++;
    if ({n_done, n_err} !== {32'd1, 32'd0}) begin
      fails++; $display("FAIL zero_pulses: got done %0d err %0d expected 1/0", n_done, n_err);
    end
  endtask

  task automatic test_timeout();
    status_mode = 1;
    run_cmd(32'h0000_0303, 32'h4000_3000, 32'd8, 1, 100);
    tests++;
    if (finished !== 1'b1) begin fails++; $display("FAIL tmo_finish: got %0d expected 1", finished); end
    tests++;
    if ({n_done, n_err} !== {32'd0, 32'd1}) begin
      fails++; $display("FAIL tmo_pulses: got done %0d err %0d expected 0/1", n_done, n_err);
    end
    // polls start in cycle 5, 20 poll cycles, then clear and error
    tests++;
    if (clr_cyc != 25) begin fails++; $display("FAIL tmo_clear_cycle: got %0d expected 25", clr_cyc); end
    tests++;
    if (err_cyc != 26) begin fails++; $display("FAIL tmo_error_cycle: got %0d expected 26", err_cyc); end
  endtask

  task automatic test_already_idle();
    status_mode = 2;
    run_cmd(32'h0000_0404, 32'h4000_4000, 32'd4, 1, 100);
    tests++;
    if (finished !== 1'b1) begin fails++; $display("FAIL idle_finish: got %0d expected 1", finished); end
    tests++;
    if ({n_done, n_err} !== {32'd0, 32'd1}) begin
      fails++; $display("FAIL idle_pulses: got done %0d err %0d expected 0/1", n_done, n_err);
    end
    tests++;
    if (err_cyc != 26 || clr_cyc != 25) begin
      fails++; $display("FAIL idle_timing: got err %0d clr %0d expected 26/25", err_cyc, clr_cyc);
    end
  endtask

  task automatic test_reset_mid();
    int stray_wr;
    stray_wr    = 0;
    status_mode = 0;
    @(negedge clock);
    bus.cmd_dest_in  = 32'h0000_0505;
    bus.cmd_addr_in  = 32'h4000_5000;
    bus.cmd_size_in  = 32'd2;
    bus.cmd_valid_in = 1'b1;
    @(posedge clock);
    #1 bus.cmd_valid_in = 1'b0;
    repeat (6) @(negedge clock);
    // cycle 6 is the first POLL_CHK: busy with an idle bus
    tests++;
    if ({bus.busy_out, bus.wb_out, bus.addr_out} !== {1'b1, 4'h0, 32'h0}) begin
      fails++; $display("FAIL mid_in_poll_chk: got busy %b wb %h addr %h expected 1/0/0",
                        bus.busy_out, bus.wb_out, bus.addr_out);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({bus.cmd_ready_out, bus.busy_out, bus.done_out, bus.error_out,
         bus.addr_out, bus.data_out, bus.wb_out} !== 72'h0) begin
      fails++; $display("FAIL mid_async_reset: got rdy %b busy %b done %b err %b addr %h data %h wb %h expected all 0",
                        bus.cmd_ready_out, bus.busy_out, bus.done_out, bus.error_out,
                        bus.addr_out, bus.data_out, bus.wb_out);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    tests++;
    if (bus.cmd_ready_out !== 1'b1) begin
      fails++; $display("FAIL mid_ready_after_release: got %b expected 1", bus.cmd_ready_out);
    end
    for (int i = 0; i < 4; i++) begin
      if (bus.wb_out != 4'h0) stray_wr++;
      @(negedge clock);
    end
    tests++;
    if (stray_wr != 0) begin fails++; $display("FAIL mid_no_clear_write: got %0d writes expected 0", stray_wr); end
    run_cmd(32'h0000_0101, 32'h4000_1000, 32'd16, 1, 100);
    tests++;
    if (finished !== 1'b1 || done_cyc != 14 || wr_addr_q.size() != 5 || n_err != 0) begin
      fails++; $display("FAIL mid_rerun: got fin %0d done %0d writes %0d err %0d expected 1/14/5/0",
                        finished, done_cyc, wr_addr_q.size(), n_err);
    end
  endtask

  task automatic test_back_to_back();
    int acc2;
    status_mode = 0;
    run_cmd(32'h0000_0606, 32'h4000_6000, 32'd32, 2, 200);
    acc2 = (acc_q.size() > 1) ? acc_q[1] : -1;
    tests++;
    if (finished !== 1'b1) begin fails++; $display("FAIL b2b_finish: got %0d expected 1", finished); end
    tests++;
    if ({n_done, n_err} !== {32'd2, 32'd0}) begin
      fails++; $display("FAIL b2b_pulses: got done %0d err %0d expected 2/0", n_done, n_err);
    end
    // first DONE in cycle 14, so cycle 15 is the first IDLE cycle
    tests++;
    if (acc2 != 15) begin fails++; $display("FAIL b2b_second_accept: got %0d expected 15", acc2); end
    tests++;
    if (overlap != 0) begin fails++; $display("FAIL b2b_ready_while_busy: got %0d cycles expected 0", overlap); end
    tests++;
    if (done_cyc != 29) begin fails++; $display("FAIL b2b_second_done: got %0d expected 29", done_cyc); end
  endtask

  initial begin
    bus.cmd_valid_in = 1'b0;
    bus.cmd_dest_in  = 32'h0;
    bus.cmd_addr_in  = 32'h0;
    bus.cmd_size_in  = 32'h0;
    test_reset();
    test_normal_send();
    test_size_zero();
    test_timeout();
    test_already_idle();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
